// File: rtl/noc_merge_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : noc_merge_arbiter_if
// Purpose  : Bundles the two requester flit streams, the merged output flit
//            stream and the select-token channel of the NoC merge arbiter.
// Signals  : in0_data/in0_valid/in0_ready  - requester 0 flit stream
//            in1_data/in1_valid/in1_ready  - requester 1 flit stream
//            out_data/out_valid/out_ready  - merged flit stream
//            s_data/s_valid/s_ready        - per-packet winner token
// Modports : slave  - the arbiter side (consumes in*, produces out/s)
//            master - the environment side (produces in*, consumes out/s)
// Revision : 1.0 - initial release
// ============================================================================
interface noc_merge_arbiter_if #(
  parameter int W = 9
);
  logic [W-1:0] in0_data;
  logic         in0_valid;
  logic         in0_ready;
  logic [W-1:0] in1_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         s_data;
  logic         s_valid;
  logic         s_ready;

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready, s_ready,
    output in0_ready, in1_ready, out_data, out_valid, s_data, s_valid
  );

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready, s_ready,
    input  in0_ready, in1_ready, out_data, out_valid, s_data, s_valid
  );
endinterface
`default_nettype wire

// File: rtl/noc_merge_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : noc_merge_arbiter
// Purpose  : Two-input packet merge. Picks one requester per packet, emits a
//            select token naming the winner, then forwards that requester's
//            flits (head through tail, tail = data[W-1]) to a registered
//            output without interleaving the two streams.
// Ports    : CLK     - clock, rising edge
//            _RESET  - asynchronous active-low reset
//            bus     - noc_merge_arbiter_if.slave (in0, in1, out, s channels)
// Revision : 1.0 - initial release
// ============================================================================
module noc_merge_arbiter #(
  parameter int W = 9
) (
  input  logic               CLK,
  input  logic               _RESET,
  noc_merge_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t       state_q;
  logic         prio_q;
  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic         s_valid_q;
  logic         s_data_q;

  logic         out_free;
  logic         slot_free;
  logic         in0_rdy;
  logic         in1_rdy;
  logic         acc0;
  logic         acc1;
  logic         acc;
  logic [W-1:0] acc_data;
  logic         tail;
  logic         grant;
  logic         winner;

  // The output register can take a flit when empty or being drained now.
  assign out_free  = !out_valid_q || bus.out_ready;
  // A new token may be written when the slot is empty or being drained now;
  // this only gates new grants, never flits of the packet in progress.
  assign slot_free = !s_valid_q || bus.s_ready;

  assign in0_rdy  = (state_q == LOCK0) && out_free;
  assign in1_rdy  = (state_q == LOCK1) && out_free;
  assign acc0     = bus.in0_valid && in0_rdy;
  assign acc1     = bus.in1_valid && in1_rdy;
  assign acc      = acc0 || acc1;
  assign acc_data = acc1 ? bus.in1_data : bus.in0_data;
  assign tail     = acc && acc_data[W-1];

  assign grant  = (state_q == IDLE) && (bus.in0_valid || bus.in1_valid) && slot_free;
  // Under contention the preferred input wins, otherwise whichever is valid.
  assign winner = (bus.in0_valid && bus.in1_valid) ? prio_q : bus.in1_valid;

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      s_valid_q   <= 1'b0;
      s_data_q    <= 1'b0;
    end else begin
      // Accept has priority over drain so a simultaneous drain+accept
      // reloads the register and sustains one flit per cycle.
      if (acc) begin
        out_data_q  <= acc_data;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (grant) begin
        s_data_q  <= winner;
        s_valid_q <= 1'b1;
        prio_q    <= ~winner;
      end else if (bus.s_ready) begin
        s_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE:         if (grant) state_q <= winner ? LOCK1 : LOCK0;
        LOCK0, LOCK1: if (tail)  state_q <= IDLE;
        default:      state_q <= IDLE;
      endcase
    end
  end

  assign bus.in0_ready = in0_rdy;
  assign bus.in1_ready = in1_rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s_data    = s_data_q;
  assign bus.s_valid   = s_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_merge_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_noc_merge_arbiter
// Purpose  : Self-checking bench for noc_merge_arbiter. A packet-level model
//            predicts the token order and merged flit stream; a monitor checks
//            every output handshake against it, and directed tests pin the
//            model with literal sequences, latencies and backpressure cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_merge_arbiter;
  localparam int W = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  noc_merge_arbiter_if #(.W(W)) bus ();

  noc_merge_arbiter #(.W(W)) dut (
    .CLK    (clk),
    ._RESET (rst_n),
    .bus    (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [W-1:0] q0[$], q1[$];          // flits still to be offered by each source
  logic [W-1:0] m0[$], m1[$];          // model copies of freshly loaded packets
  logic [W-1:0] exp_out[$], obs_out[$];
  int           exp_s[$], obs_s[$], obs_cyc[$];
  bit           mprio;
  logic         prev_stall;
  logic [W-1:0] prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level arbitration: whole packets, prio input wins contention,
  // prio flips to the loser after each grant.
  task automatic model_run();
    int w;
    while (m0.size() > 0 || m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) w = int'(mprio);
      else w = (m1.size() > 0) ? 1 : 0;
      exp_s.push_back(w);
      forever begin
        logic [W-1:0] f;
        if (w == 1) f = m1.pop_front();
        else        f = m0.pop_front();
        exp_out.push_back(f);
        if (f[W-1]) break;
        if (w == 1 && m1.size() == 0) break;
        if (w == 0 && m0.size() == 0) break;
      end
      mprio = (w == 0);
    end
  endtask

  task automatic load(input int port, input logic [W-1:0] f);
    if (port == 0) begin
      q0.push_back(f); m0.push_back(f);
      if (!bus.in0_valid) begin bus.in0_valid = 1'b1; bus.in0_data = f; end
    end else begin
      q1.push_back(f); m1.push_back(f);
      if (!bus.in1_valid) begin bus.in1_valid = 1'b1; bus.in1_data = f; end
    end
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); m0.delete(); m1.delete();
    exp_out.delete(); exp_s.delete();
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    clear_all();
    @(posedge clk); #2;
    rst_n = 1'b1;
    mprio = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((exp_out.size() > 0 || exp_s.size() > 0 || q0.size() > 0 || q1.size() > 0) && k < 300) begin
      @(posedge clk);
      k++;
    end
    check({name, "_completes"}, int'(k < 300), 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Source drivers: hold valid/data until the handshake, then present the next flit.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.in0_valid && bus.in0_ready) begin
        @(posedge clk); #1;
        if (q0.size() > 0) void'(q0.pop_front());
        bus.in0_valid = (q0.size() > 0);
        if (q0.size() > 0) bus.in0_data = q0[0];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.in1_valid && bus.in1_ready) begin
        @(posedge clk); #1;
        if (q1.size() > 0) void'(q1.pop_front());
        bus.in1_valid = (q1.size() > 0);
        if (q1.size() > 0) bus.in1_data = q1[0];
      end
    end
  end

  // Monitor: handshakes seen at the negedge complete on the next rising edge.
  initial begin
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("out_hold_valid", int'(bus.out_valid), 1);
          check("out_hold_data", int'(bus.out_data), int'(prev_data));
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (bus.in0_ready || bus.in1_ready)
          check("ready_exclusive", int'(bus.in0_ready & bus.in1_ready), 0);
        if (bus.out_valid && bus.out_ready) begin
          obs_out.push_back(bus.out_data);
          obs_cyc.push_back(cyc);
          if (exp_out.size() == 0) check("out_flit_expected", 0, 1);
          else check("out_data", int'(bus.out_data), int'(exp_out.pop_front()));
        end
        if (bus.s_valid && bus.s_ready) begin
          obs_s.push_back(int'(bus.s_data));
          if (exp_s.size() == 0) check("s_token_expected", 0, 1);
          else check("s_data", int'(bus.s_data), exp_s.pop_front());
        end
      end
    end
  end

  initial begin
    int n, bs, bo, k;
    logic [W-1:0] hold;
    rst_n = 1'b0;
    mprio = 1'b0;
    bus.in0_valid = 1'b0; bus.in0_data = '0;
    bus.in1_valid = 1'b0; bus.in1_data = '0;
    bus.out_ready = 1'b1; bus.s_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_s_valid", int'(bus.s_valid), 0);
    check("rst_s_data", int'(bus.s_data), 0);
    check("rst_in0_ready", int'(bus.in0_ready), 0);
    check("rst_in1_ready", int'(bus.in1_ready), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // ---- single requester, 3-flit packet ----
    bs = obs_s.size(); bo = obs_out.size();
    load(0, 9'h011); load(0, 9'h022); load(0, 9'h123);
    model_run();
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.out_valid && n < 10);
    check("single_head_latency", n, 2);
    check("single_flit0", int'(bus.out_data), 'h011);
    @(posedge clk); #1;
    check("single_flit1", int'(bus.out_data), 'h022);
    @(posedge clk); #1;
    check("single_flit2", int'(bus.out_data), 'h123);
    wait_done("single");
    check("single_tokens", obs_s.size() - bs, 1);
    check("single_token0", obs_s[bs], 0);
    check("single_idle_rdy0", int'(bus.in0_ready), 0);
    check("single_idle_rdy1", int'(bus.in1_ready), 0);

    // ---- contention from reset, 2-flit packets on both inputs ----
    do_reset();
    bs = obs_s.size(); bo = obs_out.size();
    load(0, 9'h0A1); load(0, 9'h1A2);
    load(1, 9'h0B1); load(1, 9'h1B2);
    model_run();
    wait_done("contention");
    check("cont_tokens", obs_s.size() - bs, 2);
    check("cont_token0", obs_s[bs], 0);
    check("cont_token1", obs_s[bs+1], 1);
    check("cont_flits", obs_out.size() - bo, 4);
    check("cont_f0", int'(obs_out[bo]),   'h0A1);
    check("cont_f1", int'(obs_out[bo+1]), 'h1A2);
    check("cont_f2", int'(obs_out[bo+2]), 'h0B1);
    check("cont_f3", int'(obs_out[bo+3]), 'h1B2);
    check("cont_in_pkt_gap", obs_cyc[bo+1] - obs_cyc[bo], 1);
    check("cont_between_pkt_gap", obs_cyc[bo+2] - obs_cyc[bo+1], 2);

    // ---- round-robin with single-flit packets ----
    bs = obs_s.size(); bo = obs_out.size();
    for (int i = 0; i < 3; i++) begin
      load(0, 9'h1AA);
      load(1, 9'h155);
    end
    model_run();
    wait_done("rr");
    check("rr_tokens", obs_s.size() - bs, 6);
    for (int i = 0; i < 6; i++) begin
      check("rr_token", obs_s[bs+i], i % 2);
      check("rr_flit", int'(obs_out[bo+i]), (i % 2 == 1) ? 'h155 : 'h1AA);
    end

    // ---- output backpressure mid-packet ----
    bs = obs_s.size(); bo = obs_out.size();
    load(0, 9'h010); load(0, 9'h020); load(0, 9'h030); load(0, 9'h140);
    model_run();
    k = 0;
    while (obs_out.size() < bo + 2 && k < 50) begin @(posedge clk); #1; k++; end
    check("obp_reach_mid", int'(k < 50), 1);
    bus.out_ready = 1'b0;
    hold = exp_out[0];
    check("obp_model_head", int'(hold), 'h030);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("obp_in0_ready", int'(bus.in0_ready), 0);
      check("obp_out_valid", int'(bus.out_valid), 1);
      check("obp_out_data", int'(bus.out_data), 'h030);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done("obp");
    check("obp_flits", obs_out.size() - bo, 4);
    check("obp_f2", int'(obs_out[bo+2]), 'h030);
    check("obp_f3", int'(obs_out[bo+3]), 'h140);

    // ---- select backpressure: packet A (in1, prio=1) then B (in0) ----
    bs = obs_s.size(); bo = obs_out.size();
    bus.s_ready = 1'b0;
    load(1, 9'h0C1); load(1, 9'h1C2);
    load(0, 9'h1D1);
    model_run();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("sbp_b_blocked", int'(bus.in0_ready), 0);
    end
    check("sbp_a_complete", exp_out.size(), 1);
    check("sbp_out_drained", int'(bus.out_valid), 0);
    check("sbp_tok_pending", int'(bus.s_valid), 1);
    check("sbp_tok_a", int'(bus.s_data), 1);
    @(posedge clk); #2;
    bus.s_ready = 1'b1;
    @(posedge clk); #1;
    check("sbp_b_grant_valid", int'(bus.s_valid), 1);
    check("sbp_b_grant_data", int'(bus.s_data), 0);
    wait_done("sbp");
    check("sbp_tokens", obs_s.size() - bs, 2);
    check("sbp_token0", obs_s[bs], 1);
    check("sbp_token1", obs_s[bs+1], 0);
    check("sbp_f2", int'(obs_out[bo+2]), 'h1D1);

    // ---- reset in the middle of an in1 packet ----
    bo = obs_out.size();
    load(1, 9'h0E1); load(1, 9'h0E2); load(1, 9'h0E3); load(1, 9'h1E4);
    model_run();
    k = 0;
    while (obs_out.size() < bo + 1 && k < 50) begin @(posedge clk); #1; k++; end
    check("mid_reach", int'(k < 50), 1);
    check("mid_out_valid_before", int'(bus.out_valid), 1);
    check("mid_in1_ready_before", int'(bus.in1_ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_out_data", int'(bus.out_data), 0);
    check("mid_rst_s_valid", int'(bus.s_valid), 0);
    check("mid_rst_in1_ready", int'(bus.in1_ready), 0);
    clear_all();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    mprio = 1'b0;
    @(posedge clk); #2;
    bs = obs_s.size(); bo = obs_out.size();
    load(1, 9'h1F1);
    load(0, 9'h1F0);
    model_run();
    wait_done("post_rst");
    check("post_rst_tokens", obs_s.size() - bs, 2);
    check("post_rst_token0", obs_s[bs], 0);
    check("post_rst_f0", int'(obs_out[bo]), 'h1F0);
    check("post_rst_f1", int'(obs_out[bo+1]), 'h1F1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
